// File: rtl/gpio_cnt_mc_if.sv
// Bundle of the per-channel trigger, threshold, clear and status signals of gpio_cnt_mc.
interface gpio_cnt_mc_if #(
    parameter int unsigned NumChan  = 4,
    parameter int unsigned CntWidth = 16
);
    logic [NumChan-1:0]  gpio_i;
    logic [CntWidth-1:0] cnt_max_i;
    logic                mode_pulse_i;
    logic [NumChan-1:0]  clr_i;
    logic [NumChan-1:0]  gpio_o;
    logic [NumChan-1:0]  busy_o;
    logic [NumChan-1:0]  event_o;
    logic                irq_o;

    modport master (
        output gpio_i, cnt_max_i, mode_pulse_i, clr_i,
        input  gpio_o, busy_o, event_o, irq_o
    );

    modport slave (
        input  gpio_i, cnt_max_i, mode_pulse_i, clr_i,
        output gpio_o, busy_o, event_o, irq_o
    );
endinterface

// File: rtl/gpio_cnt_mc.sv
// Multi-channel GPIO delay/qualify counter with latched thresholds, level/pulse output and
// sticky events. Define GPIO_CNT_MC_ABORT_EN to abort a count when the input drops early.
module gpio_cnt_mc #(
    parameter int unsigned NumChan  = 4,
    parameter int unsigned CntWidth = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    gpio_cnt_mc_if.slave bus
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCount  = 2'd1;
    localparam logic [1:0] StSetOut = 2'd2;

    logic [1:0]          state_q [NumChan];
    logic [1:0]          state_d [NumChan];
    logic [CntWidth-1:0] cnt_q   [NumChan];
    logic [CntWidth-1:0] cnt_d   [NumChan];
    logic [CntWidth-1:0] max_q   [NumChan];
    logic [CntWidth-1:0] max_d   [NumChan];
    // first_q marks the first cycle spent in SET_OUT, used by pulse mode.
    logic [NumChan-1:0]  first_q, first_d;
    logic [NumChan-1:0]  event_q, event_d;
    logic [NumChan-1:0]  gpio_vec, busy_vec;

    always_comb begin
        for (int unsigned i = 0; i < NumChan; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            max_d[i]   = max_q[i];
            first_d[i] = 1'b0;
            event_d[i] = event_q[i] & ~bus.clr_i[i];
            case (state_q[i])
                StIdle: begin
                    if (bus.gpio_i[i]) begin
                        state_d[i] = StCount;
                        cnt_d[i]   = '0;
                        max_d[i]   = bus.cnt_max_i;
                    end
                end
                StCount: begin
`ifdef GPIO_CNT_MC_ABORT_EN
                    if (!bus.gpio_i[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else
`endif
                    if (cnt_q[i] == max_q[i]) begin
                        state_d[i] = StSetOut;
                        cnt_d[i]   = '0;
                        first_d[i] = 1'b1;
                        event_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntWidth'(1);
                    end
                end
                StSetOut: begin
                    if (!bus.gpio_i[i]) begin
                        state_d[i] = StIdle;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumChan; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                max_q[i]   <= '0;
            end
            first_q <= '0;
            event_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            first_q <= first_d;
            event_q <= event_d;
        end
    end

    always_comb begin
        gpio_vec = '0;
        busy_vec = '0;
        for (int unsigned i = 0; i < NumChan; i++) begin
            gpio_vec[i] = (state_q[i] == StSetOut) & (~bus.mode_pulse_i | first_q[i]);
            busy_vec[i] = (state_q[i] == StCount);
        end
    end

    assign bus.gpio_o  = gpio_vec;
    assign bus.busy_o  = busy_vec;
    assign bus.event_o = event_q;
    assign bus.irq_o   = |event_q;
endmodule

// File: doc/gpio_cnt_mc.md
# gpio_cnt_mc

Multi-channel, parametrised GPIO delay/qualify counter for the peripheral subsystem. Each of `NumChan` independent channels waits for its input to go high, counts a runtime-programmable number of cycles, then drives its output high until the input falls. Compared with a single-channel fixed-threshold counter, it adds:
- a latched per-channel threshold,
- level/pulse output modes,
- sticky event flags with a combined interrupt,
- optional glitch abort.

## Interface
- `NumChan`, 4: number of independent channels (1..32).
- `CntWidth`, 16: width of counters and threshold (2..32).
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `gpio_i`  in  NumChan  per-channel trigger inputs, already synchronised upstream.
- `cnt_max_i`  in  CntWidth  shared threshold, latched per channel when that channel starts counting.
- `mode_pulse_i`  in  1  0 = level output, 1 = single-cycle pulse output.
- `clr_i`  in  NumChan  per-channel clear strobe for `event_o`.
- `gpio_o`  out  NumChan  per-channel qualified outputs.
- `busy_o`  out  NumChan  high while the channel is in COUNT.
- `event_o`  out  NumChan  sticky flag, set when the channel reaches SET_OUT.
- `irq_o`  out  1  OR-reduction of `event_o`.

## Operation
- Each channel is an independent FSM with states IDLE, COUNT and SET_OUT, plus a counter `cnt` and a latched threshold `max_q`, both `CntWidth` bits.
- IDLE:
  - If `gpio_i`=1 → go to COUNT, `cnt`←0, `max_q`←`cnt_max_i`.
- COUNT:
  - If `cnt`==`max_q` → go to SET_OUT, `cnt`←0, set `event_o`.
  - Otherwise `cnt`←`cnt`+1.
  - `gpio_i` is ignored in COUNT unless the Configuration macro is defined.
- SET_OUT:
  - If `gpio_i`=0 → go to IDLE.
  - Otherwise stay in SET_OUT. The input must fall before the channel can re-arm; no retrigger occurs while `gpio_i` stays high.
- Any unreachable state encoding → IDLE, `cnt`←0.
- Output modes:
  - Level mode: `gpio_o`=1 for every cycle spent in SET_OUT.
  - Pulse mode: `gpio_o`=1 only on the first cycle in SET_OUT, then 0 for the rest of the stay.
  - `mode_pulse_i` is read combinationally every cycle. Changing it during SET_OUT affects only the following cycles.
- Counter arithmetic:
  - Unsigned compare with `max_q`.
  - `cnt` cannot exceed `max_q`, so there is no wrap. `cnt_max_i` = 2^CntWidth−1 is legal.
- Threshold latching: changes to `cnt_max_i` while a channel is in COUNT do not affect that channel.
- Event flags:
  - `event_o[i]` is cleared by `clr_i[i]`.
  - If set and clear happen in the same cycle, set wins.
  - `irq_o` is combinational from `event_o`.
- Reset (`rst_i`=1 at an edge): every channel → IDLE, `cnt`=0, `max_q`=0, `event_o`=0. This also applies mid-count or mid-SET_OUT.
- Reset values of outputs: `gpio_o`=0, `busy_o`=0, `event_o`=0, `irq_o`=0.

## Timing
- `gpio_o`, `busy_o` and `event_o` are decoded from registers only. There is no combinational path from `gpio_i`.
- Latency, with edge E0 the first edge that samples `gpio_i`=1 in IDLE and M = `cnt_max_i` at E0:
  - `busy_o` rises after E0.
  - The COUNT→SET_OUT transition occurs at E(M+1).
  - `gpio_o` and `event_o` rise after E(M+1), i.e. `gpio_o` goes high M+2 edges after the input is first seen.
- M=0 gives a latency of 2 edges and `busy_o` high for exactly 1 cycle.
- Falling edge: `gpio_i` sampled 0 in SET_OUT at edge F → `gpio_o` low after F. A new COUNT can start at edge F+1 at the earliest.
- Channels never interact, apart from sharing `cnt_max_i` and `mode_pulse_i`.

## Configuration
- Macro: `GPIO_CNT_MC_ABORT_EN`.
- Defined:
  - In COUNT, `gpio_i`=0 at an edge → go to IDLE, `cnt`←0, no event. This gives debounce/glitch rejection.
  - The abort check takes priority over the threshold compare in the same cycle.
- Undefined: COUNT ignores `gpio_i`; the output still asserts after a short glitch.

## Test plan
- Reset mid-count:
  - Stimulus: NumChan=4, M=5; `gpio_i[0]` rises; `rst_i` pulsed at the third count edge.
  - Required: all outputs 0 the next cycle; `busy_o[0]`=0; a fresh trigger then needs the full 7 edges.
- Latency and release:
  - Stimulus: M=3, level mode, `gpio_i[1]` held high.
  - Required: `gpio_o[1]` high exactly 5 edges after first sample; stays high; drops 1 edge after `gpio_i` falls; `event_o[1]`=1 and `irq_o`=1.
- Pulse mode and threshold latching:
  - Stimulus: M=2, `mode_pulse_i`=1; change `cnt_max_i` to 100 during COUNT.
  - Required: `gpio_o` high for exactly 1 cycle at edge 4; the threshold change is ignored.
- Boundaries:
  - Stimulus (a): M=0. Required: `gpio_o` high after 2 edges.
  - Stimulus (b): CntWidth=4, M=15. Required: 17-edge latency, no wrap.
- Event clear:
  - Stimulus: `clr_i[2]` asserted in the same cycle `event_o[2]` sets.
  - Required: `event_o[2]` stays 1; a later `clr_i[2]` clears it and `irq_o` falls.
- Glitch:
  - Stimulus: 2-cycle `gpio_i[3]` glitch with M=10.
  - Required with `GPIO_CNT_MC_ABORT_EN`: no output and no event.
  - Required without it: `gpio_o[3]` rises 12 edges after the first sample, then drops 1 edge later because the input is already low.
